// File: rtl/id_ex_pkg.sv
// ID/EX pipeline register: shared widths and control bundle.
// Control bundle order is MSB first, as presented by the decoder.
package id_ex_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int REG_AW_DEF  = 5;
  localparam int ALUOP_W_DEF = 4;
  localparam int CTRL_W      = 4 + ALUOP_W_DEF + 2;

  typedef struct packed {
    logic                   reg_write;
    logic                   mem_to_reg;
    logic                   mem_write;
    logic                   mem_read;
    logic [ALUOP_W_DEF-1:0] alu_op;
    logic                   alu_src;
    logic                   reg_dst;
  } ctrl_t;

  // Strip the architecturally visible side effects from a bundle.
  function automatic ctrl_t ctrl_inert(input ctrl_t c);
    ctrl_t r;
    r           = c;
    r.reg_write = 1'b0;
    r.mem_write = 1'b0;
    r.mem_read  = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/id_ex_skid_buf.sv
// One-entry skid register for the ID/EX stage.
// Holds a flat bundle with its own valid bit; flush empties it.
module id_ex_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Next entry: flush wins, then load, then unload.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  // Entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake and flush.
// Define ID_EX_SKID_EN for a registered inReady backed by a skid entry.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int ALUOP_W = ALUOP_W_DEF
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic                  flush,
  input  logic [ALUOP_W+5:0]    ctrlIn,
  input  logic [DATA_W-1:0]     PCplus4,
  input  logic [DATA_W-1:0]     data1Input,
  input  logic [DATA_W-1:0]     data2Input,
  input  logic [DATA_W-1:0]     signExtendResultInput,
  input  logic [3*REG_AW-1:0]   registerAddressInput,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [ALUOP_W+5:0]    ctrlOut,
  output logic [DATA_W-1:0]     PCplus4out,
  output logic [DATA_W-1:0]     data1Output,
  output logic [DATA_W-1:0]     data2Output,
  output logic [DATA_W-1:0]     signExtendResultOutput,
  output logic [REG_AW-1:0]     rsOut,
  output logic [REG_AW-1:0]     rtOut,
  output logic [REG_AW-1:0]     rdOut
);

  localparam int CW = ALUOP_W + 6;
  localparam int BW = CW + 4 * DATA_W + 3 * REG_AW;

  // regWrite, memWrite, memRead positions in the bundle
  localparam logic [CW-1:0] WR_BITS =
    {4'b1011, {(ALUOP_W + 2){1'b0}}};

  logic [BW-1:0] in_bus;
  logic [BW-1:0] main_q;
  logic [BW-1:0] main_d;
  logic          valid_q;
  logic          valid_d;
  logic          accept;
  logic          consume;
  logic          load_main;
  logic [CW-1:0] ctrl_raw;

  assign in_bus = {ctrlIn, PCplus4, data1Input,
                   data2Input, signExtendResultInput,
                   registerAddressInput};

  assign accept  = inValid & inReady;
  assign consume = valid_q & outReady;

`ifdef ID_EX_SKID_EN
  logic          skid_valid;
  logic          skid_load;
  logic          skid_unload;
  logic [BW-1:0] skid_bus;
  logic          rdy_q;
  logic          rdy_d;

  assign skid_load   = accept & valid_q & ~outReady;
  assign skid_unload = skid_valid & consume & ~flush;
  assign load_main   = accept & (~valid_q | outReady);
  assign inReady     = rdy_q & ~flush;

  id_ex_skid_buf #(
    .W(BW)
  ) u_skid (
    .clk   (clock),
    .rst_n (resetN),
    .flush (flush),
    .load  (skid_load),
    .unload(skid_unload),
    .din   (in_bus),
    .valid (skid_valid),
    .dout  (skid_bus)
  );

  // Ready next cycle iff the skid entry will be empty.
  always_comb begin
    rdy_d = ~skid_valid;
    if (flush) begin
      rdy_d = 1'b1;
    end else if (skid_load) begin
      rdy_d = 1'b0;
    end else if (skid_unload) begin
      rdy_d = 1'b1;
    end
  end

  // Registered ready: no outReady-to-inReady path.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rdy_q <= 1'b1;
    end else begin
      rdy_q <= rdy_d;
    end
  end
`else
  assign inReady   = ~flush & (~valid_q | outReady);
  assign load_main = accept;
`endif

  // Main entry: flush, then new input, then skid refill, then drain.
  always_comb begin
    valid_d = valid_q;
    main_d  = main_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load_main) begin
      valid_d = 1'b1;
      main_d  = in_bus;
`ifdef ID_EX_SKID_EN
    end else if (skid_unload) begin
      valid_d = 1'b1;
      main_d  = skid_bus;
`endif
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  // Main entry registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      valid_q <= 1'b0;
      main_q  <= '0;
    end else begin
      valid_q <= valid_d;
      main_q  <= main_d;
    end
  end

  assign {ctrl_raw, PCplus4out, data1Output,
          data2Output, signExtendResultOutput,
          rsOut, rtOut, rdOut} = main_q;

  assign outValid = valid_q;
  assign ctrlOut  = valid_q ? ctrl_raw
                            : (ctrl_raw & ~WR_BITS);

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_id_ex_stage;
  import id_ex_pkg::*;

  localparam logic [9:0] WMASK = 10'h2C0;

`ifdef ID_EX_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clock = 1'b0;
  logic        resetN;
  logic        inValid;
  logic        inReady;
  logic        flush;
  logic [9:0]  ctrlIn;
  logic [31:0] PCplus4;
  logic [31:0] data1Input;
  logic [31:0] data2Input;
  logic [31:0] signExtendResultInput;
  logic [14:0] registerAddressInput;
  logic        outValid;
  logic        outReady;
  logic [9:0]  ctrlOut;
  logic [31:0] PCplus4out;
  logic [31:0] data1Output;
  logic [31:0] data2Output;
  logic [31:0] signExtendResultOutput;
  logic [4:0]  rsOut;
  logic [4:0]  rtOut;
  logic [4:0]  rdOut;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  id_ex_stage dut (
    .clock                 (clock),
    .resetN                (resetN),
    .inValid               (inValid),
    .inReady               (inReady),
    .flush                 (flush),
    .ctrlIn                (ctrlIn),
    .PCplus4               (PCplus4),
    .data1Input            (data1Input),
    .data2Input            (data2Input),
    .signExtendResultInput (signExtendResultInput),
    .registerAddressInput  (registerAddressInput),
    .outValid              (outValid),
    .outReady              (outReady),
    .ctrlOut               (ctrlOut),
    .PCplus4out            (PCplus4out),
    .data1Output           (data1Output),
    .data2Output           (data2Output),
    .signExtendResultOutput(signExtendResultOutput),
    .rsOut                 (rsOut),
    .rtOut                 (rtOut),
    .rdOut                 (rdOut)
  );

  typedef struct {
    logic [9:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [14:0] addr;
  } ent_t;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic [31:0] pc;
    logic [14:0] addr;
    logic [9:0]  ctrl;
    logic        ev;
    logic        er;
    logic [31:0] epc;
    logic [14:0] eaddr;
    logic [9:0]  ectrl;
  } vec_t;

  vec_t tbl[11];
  ent_t q[$];

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h",
               nm, got, exp);
    end
  endtask

  function automatic logic [9:0] mk_ctrl(
    input logic rw, m2r, mw, mr,
    input logic [3:0] op,
    input logic src, dst);
    ctrl_t c;
    c.reg_write  = rw;
    c.mem_to_reg = m2r;
    c.mem_write  = mw;
    c.mem_read   = mr;
    c.alu_op     = op;
    c.alu_src    = src;
    c.reg_dst    = dst;
    return c;
  endfunction

  task automatic drv(input logic iv, ordy, fl,
                     input logic [31:0] pc, d1,
                     input logic [9:0] ct,
                     input logic [14:0] ad);
    inValid               = iv;
    outReady              = ordy;
    flush                 = fl;
    PCplus4               = pc;
    data1Input            = d1;
    data2Input            = ~pc;
    signExtendResultInput = pc + 32'd1;
    ctrlIn                = ct;
    registerAddressInput  = ad;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  logic [9:0] ct0;
  logic [9:0] ct1;
  logic       exp_ir;
  logic       acc;
  logic       cons;
  ent_t       e;

  initial begin
    ct0 = mk_ctrl(1, 1, 1, 1, 4'h5, 1, 1);
    ct1 = mk_ctrl(1, 0, 1, 0, 4'hA, 1, 0);

    for (int i = 0; i < 8; i++) begin
      tbl[i].iv    = 1'b1;
      tbl[i].ordy  = 1'b1;
      tbl[i].pc    = 32'(4 * (i + 1));
      tbl[i].addr  = 15'(i);
      tbl[i].ctrl  = ct0;
      tbl[i].ev    = (i > 0);
      tbl[i].er    = 1'b1;
      tbl[i].epc   = 32'(4 * i);
      tbl[i].eaddr = 15'(i - 1);
      tbl[i].ectrl = ct0;
    end
    tbl[8] = '{1'b1, 1'b1, 32'd36, 15'h0CFF, ct1,
               1'b1, 1'b1, 32'd32, 15'd7, ct0};
    tbl[9] = '{1'b0, 1'b1, 32'd0, 15'd0, ct0,
               1'b1, 1'b1, 32'd36, 15'h0CFF, ct1};
    tbl[10] = '{1'b0, 1'b1, 32'd0, 15'd0, ct0,
                1'b0, 1'b1, 32'd0, 15'd0, 10'd0};

    // reset state
    resetN = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    @(negedge clock);
    chk("rst_outValid", 64'(outValid), 64'd0);
    chk("rst_ctrlOut", 64'(ctrlOut), 64'd0);
    chk("rst_pc", 64'(PCplus4out), 64'd0);
    resetN = 1'b1;
    tick();
    chk("rst_inReady", 64'(inReady), 64'd1);

    // throughput and field mapping table
    for (int i = 0; i < 11; i++) begin
      drv(tbl[i].iv, tbl[i].ordy, 0, tbl[i].pc,
          tbl[i].pc ^ 32'h5A5A0000,
          tbl[i].ctrl, tbl[i].addr);
      #1;
      chk($sformatf("tbl%0d_inReady", i),
          64'(inReady), 64'(tbl[i].er));
      chk($sformatf("tbl%0d_outValid", i),
          64'(outValid), 64'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i),
            64'(PCplus4out), 64'(tbl[i].epc));
        chk($sformatf("tbl%0d_d1", i),
            64'(data1Output),
            64'(tbl[i].epc ^ 32'h5A5A0000));
        chk($sformatf("tbl%0d_addr", i),
            64'({rsOut, rtOut, rdOut}),
            64'(tbl[i].eaddr));
        chk($sformatf("tbl%0d_ctrl", i),
            64'(ctrlOut), 64'(tbl[i].ectrl));
      end else begin
        chk($sformatf("tbl%0d_inert", i),
            64'(ctrlOut & WMASK), 64'd0);
      end
      tick();
    end

    // stall with DEADBEEF held for three cycles
    drv(1, 0, 0, 32'd100, 32'hDEADBEEF, ct0, 15'd1);
    #1;
    chk("stall_acc_inReady", 64'(inReady), 64'd1);
    tick();
    for (int k = 1; k <= 3; k++) begin
      drv(1, 0, 0, 32'd200, 32'hCAFEF00D, ct1, 15'd2);
      #1;
`ifdef ID_EX_SKID_EN
      exp_ir = (k == 1);
`else
      exp_ir = 1'b0;
`endif
      chk($sformatf("stall%0d_inReady", k),
          64'(inReady), 64'(exp_ir));
      chk($sformatf("stall%0d_outValid", k),
          64'(outValid), 64'd1);
      chk($sformatf("stall%0d_d1", k),
          64'(data1Output), 64'hDEADBEEF);
      chk($sformatf("stall%0d_pc", k),
          64'(PCplus4out), 64'd100);
      tick();
    end
    drv(0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("drain0_pc", 64'(PCplus4out), 64'd100);
    chk("drain0_valid", 64'(outValid), 64'd1);
    tick();
`ifdef ID_EX_SKID_EN
    chk("drain1_valid", 64'(outValid), 64'd1);
    chk("drain1_pc", 64'(PCplus4out), 64'd200);
    chk("drain1_d1", 64'(data1Output), 64'hCAFEF00D);
    tick();
`endif
    chk("drain_end_valid", 64'(outValid), 64'd0);

    // flush on a full stage with a new input offered
    drv(1, 0, 0, 32'd300, 32'd3, ct0, 15'd3);
    tick();
    drv(1, 1, 1, 32'd400, 32'd4, ct0, 15'd4);
    #1;
    chk("flush_inReady", 64'(inReady), 64'd0);
    chk("flush_pre_valid", 64'(outValid), 64'd1);
    tick();
    drv(0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("flush_valid", 64'(outValid), 64'd0);
    chk("flush_memWrite", 64'(ctrlOut[7]), 64'd0);
    chk("flush_regWrite", 64'(ctrlOut[9]), 64'd0);
    tick();
    chk("flush_not_taken", 64'(outValid), 64'd0);

    // reset while stalled, then one-cycle latency again
    drv(1, 0, 0, 32'd500, 32'd5, ct0, 15'd5);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0);
    #2;
    resetN = 1'b0;
    #1;
    chk("mrst_valid", 64'(outValid), 64'd0);
    chk("mrst_ctrl", 64'(ctrlOut), 64'd0);
    chk("mrst_pc", 64'(PCplus4out), 64'd0);
    chk("mrst_inReady", 64'(inReady), 64'd1);
    @(negedge clock);
    resetN = 1'b1;
    drv(1, 1, 0, 32'd600, 32'd6, ct1, 15'd6);
    #1;
    chk("post_rst_inReady", 64'(inReady), 64'd1);
    chk("post_rst_valid0", 64'(outValid), 64'd0);
    tick();
    drv(0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("post_rst_valid1", 64'(outValid), 64'd1);
    chk("post_rst_pc", 64'(PCplus4out), 64'd600);
    tick();

    // random traffic against the queue model
    q.delete();
    for (int c = 0; c < 400; c++) begin
      e.ctrl = 10'($urandom);
      e.pc   = $urandom;
      e.d1   = $urandom;
      e.addr = 15'($urandom);
      e.d2   = ~e.pc;
      e.imm  = e.pc + 32'd1;
      drv($urandom_range(0, 3) != 0,
          $urandom_range(0, 2) != 0,
          $urandom_range(0, 19) == 0,
          e.pc, e.d1, e.ctrl, e.addr);
      #1;
      if (flush) exp_ir = 1'b0;
`ifdef ID_EX_SKID_EN
      else exp_ir = (q.size() < DEPTH);
`else
      else exp_ir = (q.size() < DEPTH) || outReady;
`endif
      chk("rnd_inReady", 64'(inReady), 64'(exp_ir));
      chk("rnd_outValid", 64'(outValid),
          64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("rnd_pc", 64'(PCplus4out), 64'(q[0].pc));
        chk("rnd_d1", 64'(data1Output), 64'(q[0].d1));
        chk("rnd_d2", 64'(data2Output), 64'(q[0].d2));
        chk("rnd_imm", 64'(signExtendResultOutput),
            64'(q[0].imm));
        chk("rnd_addr", 64'({rsOut, rtOut, rdOut}),
            64'(q[0].addr));
        chk("rnd_ctrl", 64'(ctrlOut), 64'(q[0].ctrl));
      end else begin
        chk("rnd_inert", 64'(ctrlOut & WMASK), 64'd0);
      end
      acc  = inValid && exp_ir;
      cons = (q.size() != 0) && outReady;
      @(posedge clock);
      if (flush) begin
        q.delete();
      end else begin
        if (cons) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
      @(negedge clock);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
